// File: rtl/instr_fetch.sv
// Instruction fetch front end: a PC register drives the instruction memory and
// feeds a 2-entry {pc, instr} queue toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misaligned
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] f_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

  // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
  function automatic logic [DATA_W-1:0] f_next_pc(input logic [DATA_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fetch_en;
  logic              w_redir_en;

  logic [DATA_W-1:0] r_pc;
  logic [1:0]        r_count;
  logic              r_head;
  logic              r_misaligned;
  logic [DATA_W-1:0] r_q_pc    [2];
  logic [DATA_W-1:0] r_q_instr [2];

  logic              w_pop;
  logic              w_push;
  logic              w_wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // BOOT never fetches or redirects: memory output is not trusted yet.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_en  = 1'b0;
    w_redir_en  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_fetch_en = !halt;
        w_redir_en = redirect_valid;
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_redir_en = redirect_valid;
        if (!halt) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign id_valid = (r_count != 2'd0);
  assign w_pop    = id_valid && id_ready;
  assign w_push   = w_fetch_en && !redirect_valid &&
                    ((r_count != 2'd2) || w_pop);
  // Tail slot is head + count (mod 2); with count 2 and a pop it reuses the head slot.
  assign w_wr_ptr = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= f_align(RESET_PC);
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (w_redir_en) begin
      r_pc    <= f_align(redirect_pc);
      r_count <= 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misaligned <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_pc <= f_next_pc(r_pc);
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_redir_en) begin
      r_q_pc[w_wr_ptr]    <= r_pc;
      r_q_instr[w_wr_ptr] <= imem_data;
    end
  end

  assign imem_addr  = r_pc;
  assign misaligned = r_misaligned;
  assign id_pc      = id_valid ? r_q_pc[r_head]    : 32'h0000_0000;
  assign id_instr   = id_valid ? r_q_instr[r_head] : NOP_WORD;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory word at byte address A holds (A>>2)+1.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        misaligned;

  int n_vec;
  int n_err;

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .misaligned    (misaligned)
  );

  assign imem_data = (imem_addr >> 2) + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    id_ready       = 1'b0;
    step();
    step();

    // Post-reset outputs
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_misal", 32'(misaligned), 32'd0);

    // BOOT cycle: no push, redirect ignored
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("boot_nopush", 32'(id_valid), 32'd0);
    chk("boot_redir_ign", imem_addr, 32'h0);
    chk("boot_misal_ign", 32'(misaligned), 32'd0);

    // Streaming, one per cycle
    step();
    chk("s0_pc", id_pc, 32'h0);
    chk("s0_instr", id_instr, 32'd1);
    chk("s0_addr", imem_addr, 32'h4);
    step();
    chk("s1_pc", id_pc, 32'h4);
    chk("s1_instr", id_instr, 32'd2);
    step();
    chk("s2_pc", id_pc, 32'h8);
    chk("s2_instr", id_instr, 32'd3);

    // Back-pressure from reset
    rst_n    = 1'b0;
    id_ready = 1'b0;
    step();
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_instr", id_instr, 32'h0000_0013);
    chk("mid_rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    step();
    step();
    step();
    step();
    step();
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", id_pc, 32'h0);
    chk("bp_instr", id_instr, 32'd1);
    chk("bp_valid", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    step();
    chk("bp_r0_pc", id_pc, 32'h4);
    chk("bp_r0_instr", id_instr, 32'd2);
    step();
    chk("bp_r1_pc", id_pc, 32'h8);
    step();
    chk("bp_r2_pc", id_pc, 32'hC);

    // Full queue then redirect with same-cycle pop
    id_ready = 1'b0;
    step();
    chk("full_head", id_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    id_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush", 32'(id_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    step();
    chk("rd_pc", id_pc, 32'h40);
    chk("rd_instr", id_instr, 32'h11);
    chk("rd_misal", 32'(misaligned), 32'd0);

    // Misaligned redirect is sticky
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_flag", 32'(misaligned), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("mis_sticky", 32'(misaligned), 32'd1);
    chk("mis_head", id_pc, 32'h64);

    // Halt with one entry queued
    halt = 1'b1;
    step();
    chk("h_popped", 32'(id_valid), 32'd0);
    chk("h_addr", imem_addr, 32'h68);
    step();
    chk("h_frozen", imem_addr, 32'h68);
    chk("h_nopush", 32'(id_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    chk("h_rd_addr", imem_addr, 32'h80);
    step();
    chk("h_still_halted", 32'(id_valid), 32'd0);
    chk("h_still_addr", imem_addr, 32'h80);
    halt = 1'b0;
    step();
    chk("h_resume_empty", 32'(id_valid), 32'd0);
    step();
    chk("h_resume_pc", id_pc, 32'h80);
    chk("h_resume_instr", id_instr, 32'h21);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("w0_pc", id_pc, 32'hFFFF_FFFC);
    chk("w0_instr", id_instr, 32'h4000_0000);
    step();
    chk("w1_pc", id_pc, 32'h0);
    chk("w1_instr", id_instr, 32'd1);
    step();
    chk("w2_pc", id_pc, 32'h4);
    chk("w2_instr", id_instr, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
